// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB + bimodal counter branch predictor with a one-cycle registered lookup.
// Define PRED_STATS_EN to add the stat_lookups / stat_mispredicts counters.
module branch_predict_unit #(
    parameter int BTB_IDX_W = 6,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict
`ifdef PRED_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 32 - BTB_IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] valid_q;
    logic [CNT_W-1:0]   cnt_q      [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [29:0]        target_mem [ENTRIES];

    logic [BTB_IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]     lk_tag, upd_tag;
    logic                 lk_hit, lk_taken, upd_hit;
    logic [31:0]          lk_next;

    assign lk_idx  = lk_pc[BTB_IDX_W+1:2];
    assign lk_tag  = lk_pc[31:BTB_IDX_W+2];
    assign upd_idx = upd_pc[BTB_IDX_W+1:2];
    assign upd_tag = upd_pc[31:BTB_IDX_W+2];

    // The table is read combinationally before the edge that commits any update,
    // so a same-cycle lookup to the updated index sees the old contents.
    assign lk_hit   = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign lk_next  = lk_taken ? {target_mem[lk_idx], 2'b00} : lk_pc + 32'd4;

    assign upd_hit  = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    // Prediction output register: flush beats stall, stall beats a new lookup.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'd0;
        end else if (flush) begin
            pred_valid  <= 1'b0;
        end else if (!stall) begin
            pred_valid <= lk_valid;
            if (lk_valid) begin
                pred_taken  <= lk_taken;
                pred_target <= lk_next;
            end
        end
    end

    // Valid bits and counters carry architectural reset state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WEAK_NT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (cnt_q[upd_idx] != '1) cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_ONE;
                end else begin
                    if (cnt_q[upd_idx] != '0) cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_ONE;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                cnt_q[upd_idx]   <= CNT_WEAK_T;
            end
        end
    end

    // NOTE: tag/target storage has no reset; its contents are only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target[31:2];
        end
    end

    logic unused_low_bits;
    assign unused_low_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

`ifdef PRED_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_lookups     <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (lk_valid && !stall && !flush) stat_lookups <= stat_lookups + 32'd1;
            if (upd_valid && upd_mispredict)  stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: table-driven lookup/update vectors with a
// prediction scoreboard, plus hand sequences for read-before-write, stall/flush and reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lk_valid, stall, flush;
    logic [31:0] lk_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_mispredict;
    logic [31:0] upd_pc, upd_target;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } exp_t;

    typedef struct {
        logic        is_upd;
        logic [31:0] pc;
        logic        tk;    // update: direction; lookup: expected pred_taken
        logic [31:0] tgt;   // update: target;    lookup: expected pred_target
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    branch_predict_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .lk_valid       (lk_valid),
        .lk_pc          (lk_pc),
        .stall          (stall),
        .flush          (flush),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pop the oldest expected prediction and compare against the DUT output.
    task automatic drain(input string name);
        exp_t e;
        check({name, ".pred_valid"}, {31'd0, pred_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
            check({name, ".pred_target"}, pred_target, e.target);
        end
    endtask

    task automatic do_lookup(input string name, input logic [31:0] pc, input logic et, input logic [31:0] etgt);
        lk_valid = 1'b1;
        lk_pc    = pc;
        exp_q.push_back('{taken: et, target: etgt});
        step();
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        drain(name);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = 1'b1;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; lk_valid = 1'b0; lk_pc = '0; stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

        #12;
        check("reset.pred_valid", {31'd0, pred_valid}, 32'd0);
        check("reset.pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset.pred_target", pred_target, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table of lookups (expected results) and updates (stimulus), applied in order.
        vecs.push_back('{1'b0, 32'h1C000000, 1'b0, 32'h1C000004});  // cold miss
        vecs.push_back('{1'b1, 32'h1C000010, 1'b1, 32'h1C000100});  // allocate
        vecs.push_back('{1'b0, 32'h1C000010, 1'b1, 32'h1C000100});
        vecs.push_back('{1'b0, 32'h1C000110, 1'b0, 32'h1C000114});  // alias miss
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 32'h1C000010, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h1C000010, 1'b0, 32'h1C000014});  // counter at 0
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 32'h1C000010, 1'b1, 32'h1C000100});
        vecs.push_back('{1'b1, 32'h1C000010, 1'b0, 32'h0});          // 3 -> 2
        vecs.push_back('{1'b0, 32'h1C000010, 1'b1, 32'h1C000100});
        vecs.push_back('{1'b0, 32'hFFFFFFFC, 1'b0, 32'h00000000});  // pc+4 wrap
        vecs.push_back('{1'b1, 32'h1C000110, 1'b0, 32'h0});          // miss not-taken: no write
        vecs.push_back('{1'b0, 32'h1C000010, 1'b1, 32'h1C000100});
        vecs.push_back('{1'b1, 32'h1C000110, 1'b1, 32'h20000000});  // replace aliased entry
        vecs.push_back('{1'b0, 32'h1C000110, 1'b1, 32'h20000000});
        vecs.push_back('{1'b0, 32'h1C000010, 1'b0, 32'h1C000014});
        vecs.push_back('{1'b1, 32'h1C000110, 1'b1, 32'h30000008});  // hit taken rewrites target
        vecs.push_back('{1'b0, 32'h1C000110, 1'b1, 32'h30000008});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_upd) begin
                do_update(vecs[i].pc, vecs[i].tk, vecs[i].tgt);
                check($sformatf("vec%0d.upd_no_pred", i), {31'd0, pred_valid}, 32'd0);
            end else begin
                do_lookup($sformatf("vec%0d", i), vecs[i].pc, vecs[i].tk, vecs[i].tgt);
            end
        end

        // Same-cycle lookup and allocating update: lookup sees pre-update table.
        upd_valid = 1'b1; upd_pc = 32'h1C000020; upd_taken = 1'b1; upd_target = 32'h1C000200;
        do_lookup("rbw.first", 32'h1C000020, 1'b0, 32'h1C000024);
        do_lookup("rbw.repeat", 32'h1C000020, 1'b1, 32'h1C000200);

        // Stall for three cycles with lk_valid toggling; an update during stall still commits.
        do_lookup("stall.pre", 32'h1C000000, 1'b0, 32'h1C000004);
        lk_valid = 1'b1; lk_pc = 32'h1C000000;
        step();
        check("stall.idle_valid", {31'd0, pred_valid}, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lk_valid = (i % 2 == 0);
            lk_pc    = 32'h1C000110;
            upd_valid = (i == 0); upd_pc = 32'h1C000000; upd_taken = 1'b1; upd_target = 32'h1C000400;
            step();
            upd_valid = 1'b0;
            check($sformatf("stall%0d.pred_valid", i), {31'd0, pred_valid}, 32'd1);
            check($sformatf("stall%0d.pred_taken", i), {31'd0, pred_taken}, 32'd0);
            check($sformatf("stall%0d.pred_target", i), pred_target, 32'h1C000004);
        end
        flush = 1'b1; lk_valid = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0; lk_valid = 1'b0;
        check("flush.pred_valid", {31'd0, pred_valid}, 32'd0);
        do_lookup("stall.upd_committed", 32'h1C000000, 1'b1, 32'h1C000400);

        // Reset asserted mid-update and mid-prediction: outputs clear at once, table is cold.
        lk_valid = 1'b1; lk_pc = 32'h1C000110;
        upd_valid = 1'b1; upd_pc = 32'h1C000030; upd_taken = 1'b1; upd_target = 32'h1C000300;
        step();
        check("prereset.pred_valid", {31'd0, pred_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset.pred_valid", {31'd0, pred_valid}, 32'd0);
        check("async_reset.pred_target", pred_target, 32'd0);
        step();
        lk_valid = 1'b0; upd_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        do_lookup("cold.upd_discarded", 32'h1C000030, 1'b0, 32'h1C000034);
        do_lookup("cold.alias_gone", 32'h1C000110, 1'b0, 32'h1C000114);
        do_lookup("cold.entry0", 32'h1C000000, 1'b0, 32'h1C000004);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL: parameter BTB_IDX_W, default 6, meaning log2 of entry count (64 entries, direct-mapped, shared BHT/BTB index).
REQ-002 SHALL: parameter CNT_W, default 2, meaning saturating-counter width (2..4).
REQ-003 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL: rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL: lk_valid  in  1  fetch lookup request.
REQ-006 SHALL: lk_pc  in  32  fetch PC, word aligned.
REQ-007 SHALL: stall  in  1  hold prediction outputs.
REQ-008 SHALL: flush  in  1  kill pending prediction.
REQ-009 SHALL: pred_valid  out  1  prediction result valid.
REQ-010 SHALL: pred_taken  out  1  predicted taken.
REQ-011 SHALL: pred_target  out  32  predicted next PC.
REQ-012 SHALL: upd_valid  in  1  execute-stage resolve update.
REQ-013 SHALL: upd_pc  in  32  PC of resolved branch.
REQ-014 SHALL: upd_taken  in  1  actual direction.
REQ-015 SHALL: upd_target  in  32  actual taken target.
REQ-016 SHALL: upd_mispredict  in  1  resolve differs from prediction.

Function
REQ-017 SHALL: index = pc[BTB_IDX_W+1:2]; tag = pc[31:BTB_IDX_W+2]; each entry = valid bit, tag, target[31:2], CNT_W-bit counter.
REQ-018 SHALL: lookup latency exactly 1 cycle: lk_valid high at cycle N (stall low) -> pred_valid high at N+1.
REQ-019 SHALL: hit = entry valid and tag equal; pred_taken = hit and counter MSB; pred_target = {target,2'b00} if pred_taken, else lk_pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
REQ-020 SHALL: stall high -> pred_valid/pred_taken/pred_target hold; new lookup ignored.
REQ-021 SHALL: flush high -> pred_valid low next cycle, overriding stall and lk_valid same cycle.
REQ-022 SHALL: update (upd_valid) on tag hit: counter +1 if upd_taken (saturate at all-ones), -1 if not (saturate at 0); target written when upd_taken.
REQ-023 SHALL: update on miss with upd_taken: allocate entry, valid=1, tag/target written, counter = weakly-taken (MSB=1, rest 0); miss with not-taken: no write.
REQ-024 SHALL: same-cycle lookup and update to same index: lookup returns pre-update contents (read-before-write); update committed.
REQ-025 SHALL: update proceeds regardless of stall and flush.

Reset
REQ-026 SHALL: rstn low -> immediately pred_valid=0, pred_taken=0, pred_target=0, all entry valid bits 0, all counters weakly-not-taken (MSB=0, rest 1).
REQ-027 SHALL: reset mid-lookup or mid-update discards that operation; first lookup after release behaves as cold table.

Configuration
REQ-028 SHALL: macro PRED_STATS_EN defined -> adds outputs stat_lookups (32) and stat_mispredicts (32), counting accepted lookups and upd_valid&upd_mispredict cycles, wrapping at 2^32, reset to 0.
REQ-029 SHALL: macro PRED_STATS_EN undefined -> stat ports and counters absent; all other behaviour identical.

Verification
REQ-030 SHALL: cold table, lookup lk_pc=0x1C000000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x1C000004.
REQ-031 SHALL: update pc=0x1C000010 taken target 0x1C000100, then lookup 0x1C000010 -> pred_taken=1, pred_target=0x1C000100.
REQ-032 SHALL: four not-taken updates then one lookup on that PC -> pred_taken=0; five taken updates -> counter saturates at 3, one not-taken -> still taken.
REQ-033 SHALL: lookup and first taken update to 0x1C000020 same cycle -> pred_taken=0 that lookup; repeat lookup -> pred_taken=1.
REQ-034 SHALL: alias 0x1C000010 vs 0x1C000110 (same index, different tag) -> lookup 0x1C000110 misses, pred_target=0x1C000114.
REQ-035 SHALL: stall high 3 cycles with lk_valid toggling -> outputs frozen; flush during stall -> pred_valid=0 next cycle.
